// File: rtl/alu_control_mc.sv
// EX-stage ALU control decode (combinational) plus iterative shift-add MULT/MULTU with HI/LO.
// Multiply takes DATA_W+1 stall cycles, then a one-cycle DONE; stall freezes upstream and no flush exists.
module alu_control_mc #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              valid_in,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        function_field,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [3:0]        alu_control,
  output logic              stall,
  output logic              mul_done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W  = $clog2(DATA_W) + 1;
  localparam int PROD_W = 2 * DATA_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] C_AND  = 4'd0;
  localparam logic [3:0] C_OR   = 4'd1;
  localparam logic [3:0] C_ADD  = 4'd2;
  localparam logic [3:0] C_SLL  = 4'd3;
  localparam logic [3:0] C_SRL  = 4'd4;
  localparam logic [3:0] C_SUB  = 4'd5;
  localparam logic [3:0] C_MULT = 4'd6;
  localparam logic [3:0] C_SLT  = 4'd7;
  localparam logic [3:0] C_MFHI = 4'd8;
  localparam logic [3:0] C_MFLO = 4'd9;
  localparam logic [3:0] C_NOR  = 4'd12;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [DATA_W-1:0] ONE_D    = DATA_W'(1);
  localparam logic [PROD_W-1:0] ONE_P    = PROD_W'(1);

  logic [1:0]        state;
  logic [PROD_W-1:0] acc;
  logic [PROD_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [CNT_W-1:0]  cnt;
  logic              neg;

  logic              is_mul_fn;
  logic              is_signed;
  logic              start;
  logic [DATA_W-1:0] a_abs;
  logic [DATA_W-1:0] b_abs;
  logic [PROD_W-1:0] sum_next;
  logic [PROD_W-1:0] prod;

  always_comb begin
    alu_control = C_AND;
    case (alu_op)
      2'd0: alu_control = C_ADD;
      2'd1: alu_control = C_SUB;
      2'd2: begin
        case (function_field)
          6'b100000: alu_control = C_ADD;
          6'b100010: alu_control = C_SUB;
          6'b100100: alu_control = C_AND;
          6'b100101: alu_control = C_OR;
          6'b100111: alu_control = C_NOR;
          6'b101010: alu_control = C_SLT;
          6'b000000: alu_control = C_SLL;
          6'b000010: alu_control = C_SRL;
          F_MULT:    alu_control = C_MULT;
          F_MULTU:   alu_control = C_MULT;
          6'b010000: alu_control = C_MFHI;
          6'b010010: alu_control = C_MFLO;
          default:   alu_control = C_AND;
        endcase
      end
      default: alu_control = C_AND;
    endcase
  end

  assign is_mul_fn = (function_field == F_MULT) || (function_field == F_MULTU);
  assign is_signed = (function_field == F_MULT);

  // Gated by arst_n so stall drops the moment reset is asserted, even with a MULT held in EX.
  assign start = arst_n && valid_in && (alu_op == 2'd2) && is_mul_fn && (state == S_IDLE);

  assign stall    = start || (state == S_BUSY);
  assign mul_done = (state == S_DONE);

  // The most negative value maps to 2^(DATA_W-1), which still fits unsigned in DATA_W bits.
  assign a_abs = (is_signed && op_a[DATA_W-1]) ? (~op_a + ONE_D) : op_a;
  assign b_abs = (is_signed && op_b[DATA_W-1]) ? (~op_b + ONE_D) : op_b;

  assign sum_next = mplier[0] ? (acc + mcand) : acc;
  assign prod     = neg ? (~sum_next + ONE_P) : sum_next;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state  <= S_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand  <= {{DATA_W{1'b0}}, a_abs};
            mplier <= b_abs;
            neg    <= is_signed && (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
            acc    <= '0;
            cnt    <= '0;
            state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          acc    <= sum_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            {hi, lo} <= prod;
            state    <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_mc.sv
// Bench for alu_control_mc: decode table, directed and random multiplies vs an arithmetic model.
module tb_alu_control_mc;

  logic        clk;
  logic        arst_n;
  logic        valid_in;
  logic [1:0]  alu_op;
  logic [5:0]  function_field;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  alu_control;
  logic        stall;
  logic        mul_done;
  logic [31:0] hi;
  logic [31:0] lo;

  logic        v8;
  logic [1:0]  aop8;
  logic [5:0]  fn8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic [3:0]  ctl8;
  logic        st8;
  logic        md8;
  logic [7:0]  hi8;
  logic [7:0]  lo8;

  int ncmp = 0;
  int nfail = 0;

  alu_control_mc #(.DATA_W(32)) dut (
    .clk(clk), .arst_n(arst_n), .valid_in(valid_in), .alu_op(alu_op),
    .function_field(function_field), .op_a(op_a), .op_b(op_b),
    .alu_control(alu_control), .stall(stall), .mul_done(mul_done), .hi(hi), .lo(lo)
  );

  alu_control_mc #(.DATA_W(8)) dut8 (
    .clk(clk), .arst_n(arst_n), .valid_in(v8), .alu_op(aop8),
    .function_field(fn8), .op_a(a8), .op_b(b8),
    .alu_control(ctl8), .stall(st8), .mul_done(md8), .hi(hi8), .lo(lo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] exp;
  } dec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          sgn;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } mul_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference product straight from the arithmetic meaning of MULT / MULTU.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    logic [63:0] pa;
    logic [63:0] pb;
    pa = sgn ? {{32{a[31]}}, a} : {32'h0, a};
    pb = sgn ? {{32{b[31]}}, b} : {32'h0, b};
    return pa * pb;
  endfunction

  function automatic logic [15:0] ref_mul8(input logic [7:0] a, input logic [7:0] b, input bit sgn);
    logic [15:0] pa;
    logic [15:0] pb;
    pa = sgn ? {{8{a[7]}}, a} : {8'h0, a};
    pb = sgn ? {{8{b[7]}}, b} : {8'h0, b};
    return pa * pb;
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Starts in the cycle after the call's first rising edge; returns during the DONE cycle.
  task automatic mul_run(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                         input bit scramble, input logic [63:0] exp, input string tag);
    int n;
    bit got;
    @(posedge clk); #1;
    valid_in = 1'b1; alu_op = 2'd2;
    function_field = sgn ? 6'b011000 : 6'b011001;
    op_a = a; op_b = b;
    n = 0; got = 1'b0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (mul_done) begin
        got = 1'b1;
        break;
      end
      if (stall) n++;
      @(posedge clk); #1;
      if (scramble) begin
        op_a = $urandom;
        op_b = $urandom;
      end
    end
    chk({tag, " done_seen"}, 64'(got), 64'd1);
    chk({tag, " stall_cycles"}, 64'(n), 64'd33);
    chk({tag, " stall_in_done"}, 64'(stall), 64'd0);
    chk({tag, " hi"}, 64'(hi), 64'(exp[63:32]));
    chk({tag, " lo"}, 64'(lo), 64'(exp[31:0]));
  endtask

  task automatic mul_run8(input logic [7:0] a, input logic [7:0] b, input bit sgn,
                          input logic [15:0] exp, input string tag);
    int n;
    bit got;
    @(posedge clk); #1;
    v8 = 1'b1; aop8 = 2'd2;
    fn8 = sgn ? 6'b011000 : 6'b011001;
    a8 = a; b8 = b;
    n = 0; got = 1'b0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (md8) begin
        got = 1'b1;
        break;
      end
      if (st8) n++;
      @(posedge clk); #1;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
    end
    chk({tag, " done_seen"}, 64'(got), 64'd1);
    chk({tag, " stall_cycles"}, 64'(n), 64'd9);
    chk({tag, " hi"}, 64'(hi8), 64'(exp[15:8]));
    chk({tag, " lo"}, 64'(lo8), 64'(exp[7:0]));
  endtask

  dec_t dtab[16];
  mul_t mtab[3];

  initial begin
    dtab[0]  = '{2'd0, 6'b100010, 4'd2};
    dtab[1]  = '{2'd1, 6'b100000, 4'd5};
    dtab[2]  = '{2'd3, 6'b011000, 4'd0};
    dtab[3]  = '{2'd2, 6'b100000, 4'd2};
    dtab[4]  = '{2'd2, 6'b100010, 4'd5};
    dtab[5]  = '{2'd2, 6'b100100, 4'd0};
    dtab[6]  = '{2'd2, 6'b100101, 4'd1};
    dtab[7]  = '{2'd2, 6'b100111, 4'd12};
    dtab[8]  = '{2'd2, 6'b101010, 4'd7};
    dtab[9]  = '{2'd2, 6'b000000, 4'd3};
    dtab[10] = '{2'd2, 6'b000010, 4'd4};
    dtab[11] = '{2'd2, 6'b011000, 4'd6};
    dtab[12] = '{2'd2, 6'b011001, 4'd6};
    dtab[13] = '{2'd2, 6'b010000, 4'd8};
    dtab[14] = '{2'd2, 6'b010010, 4'd9};
    dtab[15] = '{2'd2, 6'b111111, 4'd0};

    mtab[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
    mtab[1] = '{32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    mtab[2] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000};

    arst_n = 1'b0; valid_in = 1'b0; alu_op = 2'd0; function_field = 6'd0;
    op_a = '0; op_b = '0;
    v8 = 1'b0; aop8 = 2'd0; fn8 = 6'd0; a8 = '0; b8 = '0;

    #12;
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset stall", 64'(stall), 64'd0);
    chk("reset mul_done", 64'(mul_done), 64'd0);
    arst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      alu_op = dtab[i].op;
      function_field = dtab[i].fn;
      #1;
      chk($sformatf("decode[%0d] alu_control", i), 64'(alu_control), 64'(dtab[i].exp));
      chk($sformatf("decode[%0d] stall", i), 64'(stall), 64'd0);
    end

    @(posedge clk); #1;
    valid_in = 1'b0; alu_op = 2'd2; function_field = 6'b011000;
    op_a = 32'd9; op_b = 32'd9;
    repeat (2) @(posedge clk);
    #1;
    chk("no_start_when_invalid stall", 64'(stall), 64'd0);
    chk("no_start_when_invalid mul_done", 64'(mul_done), 64'd0);

    for (int i = 0; i < 3; i++)
      mul_run(mtab[i].a, mtab[i].b, mtab[i].sgn, i != 0, {mtab[i].exp_hi, mtab[i].exp_lo},
              $sformatf("directed[%0d]", i));

    @(posedge clk); #1;
    valid_in = 1'b0;
    #1;
    chk("mul_done single pulse", 64'(mul_done), 64'd0);
    chk("idle stall after done", 64'(stall), 64'd0);

    mul_run(32'd1234, 32'd5678, 1'b0, 1'b0, ref_mul(32'd1234, 32'd5678, 1'b0), "b2b first");
    mul_run(32'hFFFF_FFF0, 32'd3, 1'b1, 1'b0, ref_mul(32'hFFFF_FFF0, 32'd3, 1'b1), "b2b second");
    @(posedge clk); #1;
    valid_in = 1'b1; alu_op = 2'd2; function_field = 6'b010010;
    #1;
    chk("mflo alu_control", 64'(alu_control), 64'd9);
    chk("mflo lo", 64'(lo), 64'hFFFF_FFD0);
    chk("mflo stall", 64'(stall), 64'd0);
    function_field = 6'b010000;
    #1;
    chk("mfhi alu_control", 64'(alu_control), 64'd8);
    chk("mfhi hi", 64'(hi), 64'hFFFF_FFFF);

    @(posedge clk); #1;
    valid_in = 1'b1; alu_op = 2'd2; function_field = 6'b011001;
    op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0;
    repeat (10) @(posedge clk);
    #1;
    chk("pre-reset busy stall", 64'(stall), 64'd1);
    arst_n = 1'b0;
    #1;
    chk("reset in busy stall", 64'(stall), 64'd0);
    chk("reset in busy mul_done", 64'(mul_done), 64'd0);
    chk("reset in busy hi", 64'(hi), 64'd0);
    chk("reset in busy lo", 64'(lo), 64'd0);
    valid_in = 1'b0;
    #2;
    arst_n = 1'b1;
    mul_run(32'd5, 32'd6, 1'b1, 1'b0, 64'd30, "after reset 5x6");

    for (int i = 0; i < 25; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      bit rs;
      bit sc;
      ra = pick32();
      rb = pick32();
      rs = 1'($urandom_range(0, 1));
      sc = 1'($urandom_range(0, 1));
      mul_run(ra, rb, rs, sc, ref_mul(ra, rb, rs), $sformatf("rand[%0d]", i));
    end

    @(posedge clk); #1;
    valid_in = 1'b0;

    mul_run8(8'h80, 8'h01, 1'b1, 16'hFF80, "w8 0x80x0x01");
    for (int i = 0; i < 8; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      bit rs;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom_range(0, 1));
      mul_run8(ra, rb, rs, ref_mul8(ra, rb, rs), $sformatf("w8 rand[%0d]", i));
    end

    @(posedge clk); #1;
    v8 = 1'b0;
    #1;
    chk("w8 mul_done single pulse", 64'(md8), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
